exu_alu_issue: RTL

Execute-stage initiator that drives the combinational ALU for the in-order core. It accepts decoded operations from ID over a valid/ready handshake and selects the ALU operands. It captures the ALU result into a 2-entry output buffer toward MEM, and resolves branches and jumps into a one-cycle redirect pulse to IF.

---
 rtl/exu_alu_issue.sv | 108 ++++++++++
 1 files changed

// File: rtl/exu_alu_issue.sv
// exu_alu_issue: execute-stage ALU operand drive, 2-entry result buffer toward MEM, branch/jump redirect
module exu_alu_issue #(
  parameter int DATA_WIDTH     = 32,
  parameter int TYPE_WIDTH     = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic                      i_id_valid,
  output logic                      o_id_ready,
  input  logic [TYPE_WIDTH-1:0]     i_id_alu_type,
  input  logic                      i_id_op1_sel,
  input  logic                      i_id_op2_sel,
  input  logic [DATA_WIDTH-1:0]     i_id_pc,
  input  logic [DATA_WIDTH-1:0]     i_id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     i_id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     i_id_imm,
  input  logic                      i_id_is_branch,
  input  logic                      i_id_is_jump,
  input  logic [REG_ADDR_WIDTH-1:0] i_id_rd_addr,
  input  logic                      i_id_rd_wen,
  output logic [TYPE_WIDTH-1:0]     o_alu_type,
  output logic [DATA_WIDTH-1:0]     o_alu_rs1_data,
  output logic [DATA_WIDTH-1:0]     o_alu_rs2_data,
  input  logic [DATA_WIDTH-1:0]     i_alu_res,
  input  logic                      i_alu_zero,
  output logic                      o_ex_valid,
  input  logic                      i_ex_ready,
  output logic [DATA_WIDTH-1:0]     o_ex_res,
  output logic [DATA_WIDTH-1:0]     o_ex_pc,
  output logic [REG_ADDR_WIDTH-1:0] o_ex_rd_addr,
  output logic                      o_ex_rd_wen,
  output logic                      o_redirect_valid,
  output logic [DATA_WIDTH-1:0]     o_redirect_pc
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] res0_q, res0_d, pc0_q, pc0_d, res1_q, res1_d, pc1_q, pc1_d, rpc_q, rpc_d;
  logic [REG_ADDR_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic wen0_q, wen0_d, wen1_q, wen1_d, rv_q, rv_d;
  logic accept, pop, load0, load1, shift, new_wen, taken;
  logic [DATA_WIDTH-1:0] new_res;
  assign o_alu_type     = i_id_alu_type;
  assign o_alu_rs1_data = i_id_op1_sel ? i_id_pc : i_id_rs1_data;
  assign o_alu_rs2_data = i_id_op2_sel ? i_id_imm : i_id_rs2_data;
  assign o_id_ready     = state_q != TWO;
  assign o_ex_valid     = state_q != EMPTY;
  assign accept         = i_id_valid & o_id_ready & ~i_flush;
  assign pop            = o_ex_valid & i_ex_ready;
  assign new_res        = i_id_is_jump ? i_id_pc + DATA_WIDTH'(4) : i_alu_res;
  assign new_wen        = i_id_rd_wen & ~i_id_is_branch;
  assign taken          = accept & (i_id_is_jump | (i_id_is_branch & ~i_alu_zero));
  assign load0          = accept & (state_q == EMPTY | (state_q == ONE & pop));
  assign load1          = accept & state_q == ONE & ~pop;
  assign shift          = pop & state_q == TWO;
  assign o_ex_res       = res0_q;
  assign o_ex_pc        = pc0_q;
  assign o_ex_rd_addr   = rd0_q;
  assign o_ex_rd_wen    = wen0_q;
  assign o_redirect_valid = rv_q;
  assign o_redirect_pc  = rpc_q;
  // next buffer occupancy, head/second entry contents and redirect
  always_comb begin
    state_d = i_flush ? EMPTY :
              (accept & ~pop) ? (state_q == EMPTY ? ONE : TWO) :
              (pop & ~accept) ? (state_q == TWO ? ONE : EMPTY) : state_q;
    res0_d  = load0 ? new_res : shift ? res1_q : res0_q;
    pc0_d   = load0 ? i_id_pc : shift ? pc1_q : pc0_q;
    rd0_d   = load0 ? i_id_rd_addr : shift ? rd1_q : rd0_q;
    wen0_d  = load0 ? new_wen : shift ? wen1_q : wen0_q;
    res1_d  = load1 ? new_res : res1_q;
    pc1_d   = load1 ? i_id_pc : pc1_q;
    rd1_d   = load1 ? i_id_rd_addr : rd1_q;
    wen1_d  = load1 ? new_wen : wen1_q;
    rv_d    = taken;
    rpc_d   = ~taken ? rpc_q :
              i_id_is_jump ? {i_alu_res[DATA_WIDTH-1:1], 1'b0} : i_id_pc + i_id_imm;
  end
  // state register with synchronous reset clearing buffer and redirect
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= EMPTY;
      res0_q  <= '0;
      pc0_q   <= '0;
      rd0_q   <= '0;
      wen0_q  <= 1'b0;
      res1_q  <= '0;
      pc1_q   <= '0;
      rd1_q   <= '0;
      wen1_q  <= 1'b0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      res0_q  <= res0_d;
      pc0_q   <= pc0_d;
      rd0_q   <= rd0_d;
      wen0_q  <= wen0_d;
      res1_q  <= res1_d;
      pc1_q   <= pc1_d;
      rd1_q   <= rd1_d;
      wen1_q  <= wen1_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end
endmodule
